// File: rtl/ipm2l_sfifo_ctrl_v1_2.sv
// Single-clock FIFO controller for an external simple-dual-port RAM with a
// 1-cycle registered read. Produces exact (zero-lag) full/empty flags, water
// level, programmable almost-full/almost-empty, sticky error flags and a
// synchronous flush. c_FWFT_EN selects standard or first-word-fall-through.
module ipm2l_sfifo_ctrl_v1_2 #(
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_FWFT_EN     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     w_en,
  output logic                     wr_ram_en,
  output logic [c_DEPTH_WIDTH-1:0] waddr,
  output logic                     wfull,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     r_en,
  output logic                     rd_ram_en,
  output logic [c_DEPTH_WIDTH-1:0] raddr,
  output logic                     rd_valid,
  output logic                     rempty,
  output logic                     almost_empty,
  output logic                     underflow,
  output logic [c_DEPTH_WIDTH:0]   water_level,
  input  logic [c_DEPTH_WIDTH:0]   af_thresh,
  input  logic [c_DEPTH_WIDTH:0]   ae_thresh
);

  localparam int N = c_DEPTH_WIDTH;
  localparam logic [N:0] FULL_LVL = {1'b1, {N{1'b0}}};

  // One extra pointer bit distinguishes full from empty; wrap is plain modulo.
  logic [N:0] wptr, rptr;
  logic [N:0] wptr_nxt, rptr_nxt;
  logic [N:0] mem_cnt;
  logic [N:0] occ_nxt;
  logic       wa, ra;
  logic       rd_valid_nxt;
  logic       rempty_nxt;

  // Accept decisions and next-cycle occupancy; every flag is derived from
  // occ_nxt so the registered flags never lag the pointers.
  always_comb begin
    wa           = w_en & ~wfull & ~flush;
    mem_cnt      = wptr - rptr;
    ra           = 1'b0;
    rd_valid_nxt = 1'b0;
    if (c_FWFT_EN != 0) begin
      // Prefetch into the RAM output register whenever it is empty or its
      // word is being consumed this cycle.
      ra = (mem_cnt != '0) & (~rd_valid | r_en) & ~flush;
      if (flush)     rd_valid_nxt = 1'b0;
      else if (ra)   rd_valid_nxt = 1'b1;
      else if (r_en) rd_valid_nxt = 1'b0;
      else           rd_valid_nxt = rd_valid;
    end else begin
      ra           = r_en & ~rempty & ~flush;
      rd_valid_nxt = ra;
    end
    wptr_nxt = wptr + {{N{1'b0}}, wa};
    rptr_nxt = rptr + {{N{1'b0}}, ra};
    // In FWFT mode the word held at the RAM output still counts as stored.
    if (c_FWFT_EN != 0) begin
      occ_nxt    = (wptr_nxt - rptr_nxt) + {{N{1'b0}}, rd_valid_nxt};
      rempty_nxt = ~rd_valid_nxt;
    end else begin
      occ_nxt    = wptr_nxt - rptr_nxt;
      rempty_nxt = (occ_nxt == '0);
    end
  end

  assign wr_ram_en = wa;
  assign rd_ram_en = ra;
  assign waddr     = wptr[N-1:0];
  assign raddr     = rptr[N-1:0];

  // State and flag registers; rst and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr         <= '0;
      rptr         <= '0;
      rd_valid     <= 1'b0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      water_level  <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      rd_valid     <= rd_valid_nxt;
      wfull        <= (occ_nxt == FULL_LVL);
      rempty       <= rempty_nxt;
      water_level  <= occ_nxt;
      almost_full  <= (occ_nxt >= af_thresh);
      almost_empty <= (occ_nxt <= ae_thresh);
      overflow     <= overflow  | (w_en & wfull);
      underflow    <= underflow | (r_en & rempty);
    end
  end

endmodule

// File: tb/tb_ipm2l_sfifo_ctrl_v1_2.sv
// Directed bench: a standard-mode instance (N=4) and an FWFT instance (N=3).
module tb_ipm2l_sfifo_ctrl_v1_2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Standard-mode instance, N=4
  logic       flush_a, w_en_a, r_en_a;
  logic [4:0] af_a, ae_a;
  logic       wr_ram_en_a, wfull_a, almost_full_a, overflow_a;
  logic       rd_ram_en_a, rd_valid_a, rempty_a, almost_empty_a, underflow_a;
  logic [3:0] waddr_a, raddr_a;
  logic [4:0] water_a;

  // FWFT instance, N=3
  logic       flush_b, w_en_b, r_en_b;
  logic [3:0] af_b, ae_b;
  logic       wr_ram_en_b, wfull_b, almost_full_b, overflow_b;
  logic       rd_ram_en_b, rd_valid_b, rempty_b, almost_empty_b, underflow_b;
  logic [2:0] waddr_b, raddr_b;
  logic [3:0] water_b;

  ipm2l_sfifo_ctrl_v1_2 #(.c_DEPTH_WIDTH(4), .c_FWFT_EN(0)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .w_en(w_en_a),
    .wr_ram_en(wr_ram_en_a), .waddr(waddr_a), .wfull(wfull_a),
    .almost_full(almost_full_a), .overflow(overflow_a), .r_en(r_en_a),
    .rd_ram_en(rd_ram_en_a), .raddr(raddr_a), .rd_valid(rd_valid_a),
    .rempty(rempty_a), .almost_empty(almost_empty_a), .underflow(underflow_a),
    .water_level(water_a), .af_thresh(af_a), .ae_thresh(ae_a)
  );

  ipm2l_sfifo_ctrl_v1_2 #(.c_DEPTH_WIDTH(3), .c_FWFT_EN(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .w_en(w_en_b),
    .wr_ram_en(wr_ram_en_b), .waddr(waddr_b), .wfull(wfull_b),
    .almost_full(almost_full_b), .overflow(overflow_b), .r_en(r_en_b),
    .rd_ram_en(rd_ram_en_b), .raddr(raddr_b), .rd_valid(rd_valid_b),
    .rempty(rempty_b), .almost_empty(almost_empty_b), .underflow(underflow_b),
    .water_level(water_b), .af_thresh(af_b), .ae_thresh(ae_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    flush_a = 1'b0; w_en_a = 1'b0; r_en_a = 1'b0; af_a = 5'd14; ae_a = 5'd2;
    flush_b = 1'b0; w_en_b = 1'b0; r_en_b = 1'b0; af_b = 4'd8;  ae_b = 4'd0;
    tick();
    tick();

    // Reset state
    check("rst_waddr",  32'(waddr_a), 32'd0);
    check("rst_raddr",  32'(raddr_a), 32'd0);
    check("rst_wfull",  32'(wfull_a), 32'd0);
    check("rst_rempty", 32'(rempty_a), 32'd1);
    check("rst_rdval",  32'(rd_valid_a), 32'd0);
    check("rst_level",  32'(water_a), 32'd0);
    check("rst_af",     32'(almost_full_a), 32'd0);
    check("rst_ae",     32'(almost_empty_a), 32'd1);
    check("rst_ovf",    32'(overflow_a), 32'd0);
    check("rst_unf",    32'(underflow_a), 32'd0);
    check("rst_b_rempty", 32'(rempty_b), 32'd1);
    rst = 1'b0;

    // Fill 16 entries
    for (int i = 0; i < 16; i++) begin
      w_en_a = 1'b1;
      #1;
      check("fill_wr_en", 32'(wr_ram_en_a), 32'd1);
      check("fill_waddr", 32'(waddr_a), 32'(i));
      tick();
      if (i == 14) check("fill_wfull_early", 32'(wfull_a), 32'd0);
    end
    check("full_wfull", 32'(wfull_a), 32'd1);
    check("full_level", 32'(water_a), 32'd16);
    check("full_af",    32'(almost_full_a), 32'd1);
    check("full_rempty", 32'(rempty_a), 32'd0);

    // 17th write is rejected
    #1;
    check("ovf_wr_en", 32'(wr_ram_en_a), 32'd0);
    check("ovf_waddr_pre", 32'(waddr_a), 32'd0);
    tick();
    w_en_a = 1'b0;
    check("ovf_flag",  32'(overflow_a), 32'd1);
    check("ovf_waddr", 32'(waddr_a), 32'd0);
    check("ovf_level", 32'(water_a), 32'd16);

    // Simultaneous write/read at full: read wins
    w_en_a = 1'b1; r_en_a = 1'b1;
    #1;
    check("fullrw_rd_en", 32'(rd_ram_en_a), 32'd1);
    check("fullrw_wr_en", 32'(wr_ram_en_a), 32'd0);
    tick();
    check("fullrw_level", 32'(water_a), 32'd15);
    check("fullrw_wfull", 32'(wfull_a), 32'd0);
    check("fullrw_rdval", 32'(rd_valid_a), 32'd1);
    check("fullrw_raddr", 32'(raddr_a), 32'd1);

    // Drain to level 8
    w_en_a = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    r_en_a = 1'b0;
    check("lvl8_level", 32'(water_a), 32'd8);
    check("lvl8_raddr", 32'(raddr_a), 32'd8);

    // Steady read+write for 40 cycles, pointers wrap
    w_en_a = 1'b1; r_en_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("steady_level",  32'(water_a), 32'd8);
      check("steady_wfull",  32'(wfull_a), 32'd0);
      check("steady_rempty", 32'(rempty_a), 32'd0);
    end
    w_en_a = 1'b0; r_en_a = 1'b0;
    check("wrap_waddr", 32'(waddr_a), 32'd8);
    check("wrap_raddr", 32'(raddr_a), 32'd0);

    // Down to 5 entries, overflow still set, then flush with w_en
    r_en_a = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    r_en_a = 1'b0;
    check("pre_flush_level", 32'(water_a), 32'd5);
    check("pre_flush_ovf",   32'(overflow_a), 32'd1);
    flush_a = 1'b1; w_en_a = 1'b1;
    #1;
    check("flush_wr_en", 32'(wr_ram_en_a), 32'd0);
    check("flush_rd_en", 32'(rd_ram_en_a), 32'd0);
    tick();
    flush_a = 1'b0; w_en_a = 1'b0;
    check("flush_level",  32'(water_a), 32'd0);
    check("flush_rempty", 32'(rempty_a), 32'd1);
    check("flush_ovf",    32'(overflow_a), 32'd0);
    check("flush_waddr",  32'(waddr_a), 32'd0);
    check("flush_raddr",  32'(raddr_a), 32'd0);
    check("flush_wfull",  32'(wfull_a), 32'd0);

    // Fill 3, read 4 back-to-back
    w_en_a = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    w_en_a = 1'b0;
    check("fill3_level", 32'(water_a), 32'd3);
    check("fill3_ae",    32'(almost_empty_a), 32'd0);
    r_en_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rd4_rd_en", 32'(rd_ram_en_a), (k < 3) ? 32'd1 : 32'd0);
      check("rd4_raddr", 32'(raddr_a), 32'(k));
      tick();
      check("rd4_rdval", 32'(rd_valid_a), (k < 3) ? 32'd1 : 32'd0);
    end
    r_en_a = 1'b0;
    check("rd4_unf",    32'(underflow_a), 32'd1);
    check("rd4_rempty", 32'(rempty_a), 32'd1);
    check("rd4_level",  32'(water_a), 32'd0);

    // Threshold change at level 4
    w_en_a = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    w_en_a = 1'b0;
    check("lvl4_level", 32'(water_a), 32'd4);
    check("lvl4_ae_before", 32'(almost_empty_a), 32'd0);
    ae_a = 5'd6;
    tick();
    check("lvl4_ae_after", 32'(almost_empty_a), 32'd1);

    // Reset mid-burst
    w_en_a = 1'b1; r_en_a = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; w_en_a = 1'b0; r_en_a = 1'b0;
    check("mrst_level",  32'(water_a), 32'd0);
    check("mrst_rempty", 32'(rempty_a), 32'd1);
    check("mrst_waddr",  32'(waddr_a), 32'd0);
    check("mrst_raddr",  32'(raddr_a), 32'd0);
    check("mrst_rdval",  32'(rd_valid_a), 32'd0);
    check("mrst_unf",    32'(underflow_a), 32'd0);
    check("mrst_ae",     32'(almost_empty_a), 32'd1);

    // FWFT: single write, two-cycle empty deassert
    w_en_b = 1'b1;
    tick();
    w_en_b = 1'b0;
    check("fw1_rempty", 32'(rempty_b), 32'd1);
    check("fw1_rdval",  32'(rd_valid_b), 32'd0);
    check("fw1_level",  32'(water_b), 32'd1);
    #1;
    check("fw1_prefetch", 32'(rd_ram_en_b), 32'd1);
    tick();
    check("fw2_rempty", 32'(rempty_b), 32'd0);
    check("fw2_rdval",  32'(rd_valid_b), 32'd1);
    check("fw2_level",  32'(water_b), 32'd1);
    check("fw2_raddr",  32'(raddr_b), 32'd1);
    tick();
    check("fw3_rdval_hold", 32'(rd_valid_b), 32'd1);
    r_en_b = 1'b1;
    #1;
    check("fw_consume_rd_en", 32'(rd_ram_en_b), 32'd0);
    tick();
    r_en_b = 1'b0;
    check("fw_consume_rempty", 32'(rempty_b), 32'd1);
    check("fw_consume_rdval",  32'(rd_valid_b), 32'd0);
    check("fw_consume_level",  32'(water_b), 32'd0);
    check("fw_consume_unf",    32'(underflow_b), 32'd0);

    // FWFT: 8 writes fill (7 in RAM + head)
    for (int i = 0; i < 8; i++) begin
      check("fw_fill_wfull", 32'(wfull_b), 32'd0);
      w_en_b = 1'b1;
      tick();
    end
    check("fw_full_wfull",  32'(wfull_b), 32'd1);
    check("fw_full_level",  32'(water_b), 32'd8);
    check("fw_full_af",     32'(almost_full_b), 32'd1);
    check("fw_full_rempty", 32'(rempty_b), 32'd0);
    check("fw_full_raddr",  32'(raddr_b), 32'd2);
    check("fw_full_waddr",  32'(waddr_b), 32'd1);
    #1;
    check("fw_ovf_wr_en", 32'(wr_ram_en_b), 32'd0);
    tick();
    w_en_b = 1'b0;
    check("fw_ovf_flag",  32'(overflow_b), 32'd1);
    check("fw_ovf_level", 32'(water_b), 32'd8);

    // FWFT: consume at full
    r_en_b = 1'b1;
    #1;
    check("fw_rdfull_rd_en", 32'(rd_ram_en_b), 32'd1);
    tick();
    r_en_b = 1'b0;
    check("fw_rdfull_wfull", 32'(wfull_b), 32'd0);
    check("fw_rdfull_level", 32'(water_b), 32'd7);
    check("fw_rdfull_rdval", 32'(rd_valid_b), 32'd1);
    check("fw_rdfull_raddr", 32'(raddr_b), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
